// File: rtl/kernel_buffer.sv
// kernel_buffer: packs a weight byte stream into kernel words and serves
// registered single-cycle reads to the convolution engine.
//
// Write handshake: a byte is transferred on a rising edge where
// wr_valid && wr_ready; wr_ready depends only on the FSM state (high in LOAD),
// never on wr_valid, so the producer may hold or drop wr_valid freely.
module kernel_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       load_start,
  input  logic                                       wr_valid,
  output logic                                       wr_ready,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  output logic                                       load_done,
  output logic                                       loaded,
  input  logic                                       kernel_rd,
  input  logic [ADDR_WIDTH-1:0]                      kernel_addr,
  output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] kernel_readdata,
  output logic                                       rd_err,
  output logic [1:0]                                 o_dbg_state
);

  localparam int NE = KERNEL_SIZE * KERNEL_SIZE;
  localparam int EW = $clog2(NE);
  localparam int WW = DATA_WIDTH * NE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [EW-1:0]         r_elem_cnt;
  logic [ADDR_WIDTH-1:0] r_word_ptr;
  logic [WW-1:0]         r_pack;
  logic [WW-1:0]         r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_last_elem;
  logic                  w_last_word;
  logic                  w_word_wr;
  logic                  w_load_fin;
  logic                  w_rd_ok;
  logic [WW-1:0]         w_word;

  // Handshake and word-completion decode
  always_comb begin
    w_accept    = 1'b0;
    w_last_elem = 1'b0;
    w_last_word = 1'b0;
    w_word_wr   = 1'b0;
    w_load_fin  = 1'b0;
    w_rd_ok     = 1'b0;
    // The final lane is the top lane, so the completed word is the pack
    // register with its top lane replaced by the byte arriving now.
    w_word      = {wr_data, r_pack[WW-DATA_WIDTH-1:0]};
    w_accept    = (r_state == S_LOAD) && wr_valid && !load_start;
    w_last_elem = (r_elem_cnt == EW'(NE - 1));
    w_last_word = (r_word_ptr == ADDR_WIDTH'(DEPTH - 1));
    w_word_wr   = w_accept && w_last_elem;
    w_load_fin  = w_word_wr && w_last_word;
    w_rd_ok     = kernel_rd && (r_state == S_READY) && (32'(kernel_addr) < DEPTH);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state and state-decoded outputs
  always_comb begin
    w_next      = r_state;
    wr_ready    = 1'b0;
    loaded      = 1'b0;
    o_dbg_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        // A restart keeps the FSM in LOAD; the counters are cleared below.
        if (load_start)      w_next = S_LOAD;
        else if (w_load_fin) w_next = S_READY;
      end
      S_READY: begin
        loaded = 1'b1;
        if (load_start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Element/word counters and the lane pack register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem_cnt <= '0;
      r_word_ptr <= '0;
      r_pack     <= '0;
    end else if (load_start) begin
      r_elem_cnt <= '0;
      r_word_ptr <= '0;
    end else if (w_accept) begin
      if (w_last_elem) begin
        r_elem_cnt <= '0;
        r_word_ptr <= r_word_ptr + 1'b1;
      end else begin
        r_pack[r_elem_cnt*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
        r_elem_cnt <= r_elem_cnt + 1'b1;
      end
    end
  end

  // Kernel storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_word_wr) r_mem[r_word_ptr] <= w_word;
  end

  // One-cycle completion pulse for the last word of a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_done <= 1'b0;
    else        load_done <= w_load_fin;
  end

  // Registered read port with error flag for rejected requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_readdata <= '0;
      rd_err          <= 1'b0;
    end else begin
      rd_err <= kernel_rd && !w_rd_ok;
      if (w_rd_ok)
        kernel_readdata <= r_mem[kernel_addr];
      else if (kernel_rd && (r_state == S_READY))
        kernel_readdata <= '0;
    end
  end

endmodule

// File: tb/tb_kernel_buffer.sv
// Directed testbench for kernel_buffer: a default-size instance and a
// DEPTH=48 instance sharing the byte stream and read request lines.
module tb_kernel_buffer;

  localparam int WW = 72;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          load_start_s;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          kernel_rd;
  logic [5:0]    kernel_addr;

  logic          wr_ready, load_done, loaded, rd_err;
  logic [WW-1:0] rd_data;
  logic [1:0]    dbg_state;
  logic          wr_ready_s, load_done_s, loaded_s, rd_err_s;
  logic [WW-1:0] rd_data_s;
  logic [1:0]    dbg_state_s;

  int checks   = 0;
  int failures = 0;

  kernel_buffer u_dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .load_done(load_done), .loaded(loaded),
    .kernel_rd(kernel_rd), .kernel_addr(kernel_addr),
    .kernel_readdata(rd_data), .rd_err(rd_err), .o_dbg_state(dbg_state)
  );

  kernel_buffer #(.DEPTH(48)) u_small (
    .clk(clk), .rst_n(rst_n), .load_start(load_start_s),
    .wr_valid(wr_valid), .wr_ready(wr_ready_s), .wr_data(wr_data),
    .load_done(load_done_s), .loaded(loaded_s),
    .kernel_rd(kernel_rd), .kernel_addr(kernel_addr),
    .kernel_readdata(rd_data_s), .rd_err(rd_err_s), .o_dbg_state(dbg_state_s)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    addr;
    logic [WW-1:0] exp_data;
    logic          exp_err;
  } rd_vec_t;

  rd_vec_t vecs[6];

  function automatic logic [WW-1:0] exp_word(input int a);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(9*a + k);
    return w;
  endfunction

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) load_start_s = 1'b1; else load_start = 1'b1;
    tick();
    load_start = 1'b0; load_start_s = 1'b0;
  endtask

  // Streams n accepted bytes; records the accepted-byte count at load_done.
  task automatic stream(input int n, input bit sel, input bit toggle, input bit aa,
                        output int done_at, output int done_cnt);
    int acc;
    int cyc;
    logic rdy;
    acc = 0; cyc = 0; done_at = -1; done_cnt = 0;
    while (acc < n && cyc < 5000) begin
      wr_valid = toggle ? ~cyc[0] : 1'b1;
      wr_data  = aa ? 8'hAA : 8'(acc);
      rdy      = sel ? wr_ready_s : wr_ready;
      tick();
      if (wr_valid && rdy) acc++;
      if (sel ? load_done_s : load_done) begin
        done_cnt++;
        done_at = acc;
      end
      cyc++;
    end
    wr_valid = 1'b0;
    if (cyc >= 5000) begin
      checks++; failures++;
      $display("FAIL stream_timeout: got %0d bytes expected %0d", acc, n);
    end
  endtask

  task automatic do_read(input logic [5:0] a);
    kernel_rd = 1'b1; kernel_addr = a;
    tick();
    kernel_rd = 1'b0;
  endtask

  task automatic full_load_check(input string tag);
    int done_at, done_cnt;
    pulse_start(1'b0);
    stream(576, 1'b0, 1'b0, 1'b0, done_at, done_cnt);
    check({tag, "_done_at"}, WW'(done_at), WW'(576));
    check({tag, "_done_cnt"}, WW'(done_cnt), WW'(1));
    check({tag, "_loaded"}, WW'(loaded), WW'(1));
    do_read(6'd0);
    check({tag, "_rd0"}, rd_data, 72'h080706050403020100);
    do_read(6'd63);
    check({tag, "_rd63"}, rd_data, 72'h3F3E3D3C3B3A393837);
  endtask

  initial begin
    int done_at, done_cnt;
    rst_n = 1'b0; load_start = 1'b0; load_start_s = 1'b0;
    wr_valid = 1'b0; wr_data = '0; kernel_rd = 1'b0; kernel_addr = '0;

    vecs[0] = '{6'd0,  72'h080706050403020100, 1'b0};
    vecs[1] = '{6'd63, 72'h3F3E3D3C3B3A393837, 1'b0};
    vecs[2] = '{6'd5,  72'h3534333231302F2E2D, 1'b0};
    vecs[3] = '{6'd31, exp_word(31),           1'b0};
    vecs[4] = '{6'd17, exp_word(17),           1'b0};
    vecs[5] = '{6'd28, exp_word(28),           1'b0};

    // Reset state
    tick(); tick();
    check("rst_state", WW'(dbg_state), WW'(0));
    check("rst_wr_ready", WW'(wr_ready), WW'(0));
    check("rst_loaded", WW'(loaded), WW'(0));
    check("rst_load_done", WW'(load_done), WW'(0));
    check("rst_rd_err", WW'(rd_err), WW'(0));
    check("rst_readdata", rd_data, '0);
    rst_n = 1'b1;
    tick();

    // Read while IDLE is rejected
    do_read(6'd3);
    check("idle_rd_err", WW'(rd_err), WW'(1));
    check("idle_rd_hold", rd_data, '0);
    tick();
    check("idle_rd_err_drop", WW'(rd_err), WW'(0));

    // Bytes outside LOAD are refused
    wr_valid = 1'b1; wr_data = 8'h55;
    tick();
    check("idle_wr_ready", WW'(wr_ready), WW'(0));
    check("idle_state_hold", WW'(dbg_state), WW'(0));
    wr_valid = 1'b0;

    // Full load, contiguous bytes
    full_load_check("load1");
    check("load1_state", WW'(dbg_state), WW'(2));

    // Table-driven single reads
    for (int i = 0; i < 6; i++) begin
      do_read(vecs[i].addr);
      check($sformatf("tbl_rd_%0d", vecs[i].addr), rd_data, vecs[i].exp_data);
      check($sformatf("tbl_err_%0d", vecs[i].addr), WW'(rd_err), WW'(vecs[i].exp_err));
    end
    tick();
    check("rd_hold", rd_data, vecs[5].exp_data);

    // Back-to-back reads 5,6,7
    kernel_rd = 1'b1;
    for (int a = 5; a < 8; a++) begin
      kernel_addr = 6'(a);
      tick();
      check($sformatf("b2b_rd_%0d", a), rd_data, exp_word(a));
    end
    kernel_rd = 1'b0;

    // load_start with a read in READY: read served from old contents
    load_start = 1'b1; kernel_rd = 1'b1; kernel_addr = 6'd9;
    tick();
    load_start = 1'b0; kernel_rd = 1'b0;
    check("ls_rd_data", rd_data, exp_word(9));
    check("ls_rd_err", WW'(rd_err), WW'(0));
    check("ls_loaded", WW'(loaded), WW'(0));
    check("ls_state", WW'(dbg_state), WW'(1));

    // Read during LOAD is rejected and readdata holds
    do_read(6'd0);
    check("load_rd_err", WW'(rd_err), WW'(1));
    check("load_rd_hold", rd_data, exp_word(9));

    // Load with wr_valid toggling
    stream(576, 1'b0, 1'b1, 1'b0, done_at, done_cnt);
    check("tog_done_at", WW'(done_at), WW'(576));
    check("tog_done_cnt", WW'(done_cnt), WW'(1));
    do_read(6'd0);
    check("tog_rd0", rd_data, 72'h080706050403020100);
    do_read(6'd40);
    check("tog_rd40", rd_data, exp_word(40));
    do_read(6'd63);
    check("tog_rd63", rd_data, 72'h3F3E3D3C3B3A393837);

    // Restart after 100 bytes, then reload with 0xAA
    pulse_start(1'b0);
    stream(100, 1'b0, 1'b0, 1'b0, done_at, done_cnt);
    check("abort_no_done", WW'(done_cnt), WW'(0));
    pulse_start(1'b0);
    check("restart_state", WW'(dbg_state), WW'(1));
    stream(576, 1'b0, 1'b0, 1'b1, done_at, done_cnt);
    check("aa_done_at", WW'(done_at), WW'(576));
    check("aa_done_cnt", WW'(done_cnt), WW'(1));
    do_read(6'd0);
    check("aa_rd0", rd_data, {9{8'hAA}});
    do_read(6'd63);
    check("aa_rd63", rd_data, {9{8'hAA}});

    // Reset in the middle of a load
    pulse_start(1'b0);
    stream(300, 1'b0, 1'b0, 1'b0, done_at, done_cnt);
    rst_n = 1'b0;
    #2;
    check("mid_rst_state", WW'(dbg_state), WW'(0));
    check("mid_rst_loaded", WW'(loaded), WW'(0));
    check("mid_rst_wr_ready", WW'(wr_ready), WW'(0));
    check("mid_rst_readdata", rd_data, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", WW'(dbg_state), WW'(0));
    check("post_rst_loaded", WW'(loaded), WW'(0));
    full_load_check("load2");

    // DEPTH=48 instance: out-of-range read returns zero with error
    pulse_start(1'b1);
    stream(432, 1'b1, 1'b0, 1'b0, done_at, done_cnt);
    check("s_done_at", WW'(done_at), WW'(432));
    check("s_loaded", WW'(loaded_s), WW'(1));
    do_read(6'd47);
    check("s_rd47", rd_data_s, exp_word(47));
    check("s_rd47_err", WW'(rd_err_s), WW'(0));
    do_read(6'd50);
    check("s_rd50", rd_data_s, '0);
    check("s_rd50_err", WW'(rd_err_s), WW'(1));
    tick();
    check("s_err_drop", WW'(rd_err_s), WW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
